// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and the arbiter FSM state encoding.
// Used by the ALU control decoder and by alu_share_arbiter.
package alu_pkg;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_OR     = 4'b0001;
    localparam logic [3:0] ALU_SLL    = 4'b0010;
    localparam logic [3:0] ALU_SRL    = 4'b0011;
    localparam logic [3:0] ALU_OP_MAX = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant with a registered priority pointer.
// ptr_q names the requester that wins when both are requesting; every
// accepted grant hands priority to the other requester.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic ptr_q;
    logic ptr_d;

    // Grant: a lone requester always wins, a tie goes to the pointer.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr_q ? 2'b10 : 2'b01;
        end
    end

    // Next pointer: on accept, point at the index that was not granted.
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = gnt[0];
        end
    end

    // Pointer register, req0 has priority out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters.
// IDLE accepts a request (round-robin), EXEC drives the ALU from registers
// and captures its result, RESP holds the result until the granted
// requester takes it. Optional feature macro: ALU_ARB_OPCHECK_EN (illegal
// op codes run as ADD with a zeroed result and raise resp_err_o).
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid_i,
    input  logic                  req1_valid_i,
    output logic                  req0_ready_o,
    output logic                  req1_ready_o,
    input  logic [DATA_WIDTH-1:0] req0_a_i,
    input  logic [DATA_WIDTH-1:0] req1_a_i,
    input  logic [DATA_WIDTH-1:0] req0_b_i,
    input  logic [DATA_WIDTH-1:0] req1_b_i,
    input  logic [3:0]            req0_op_i,
    input  logic [3:0]            req1_op_i,
    output logic                  resp0_valid_o,
    output logic                  resp1_valid_o,
    input  logic                  resp0_ready_i,
    input  logic                  resp1_ready_i,
    output logic [DATA_WIDTH-1:0] resp_data_o,
    output logic [DATA_WIDTH-1:0] alu_a_o,
    output logic [DATA_WIDTH-1:0] alu_b_o,
    output logic [3:0]            alu_op_o,
`ifdef ALU_ARB_OPCHECK_EN
    output logic                  resp_err_o,
`endif
    input  logic [DATA_WIDTH-1:0] alu_result_i
);

    arb_state_t            state_q;
    logic                  gnt_idx_q;
    logic [DATA_WIDTH-1:0] alu_a_q;
    logic [DATA_WIDTH-1:0] alu_b_q;
    logic [3:0]            alu_op_q;
    logic [DATA_WIDTH-1:0] resp_data_q;

    logic [1:0]            req_vld;
    logic [1:0]            gnt;
    logic                  accept;
    logic                  resp_take;
    logic [DATA_WIDTH-1:0] sel_a_d;
    logic [DATA_WIDTH-1:0] sel_b_d;
    logic [3:0]            sel_op_d;
    logic [3:0]            alu_op_d;

    assign req_vld = {req1_valid_i, req0_valid_i};

    // Accept only in IDLE; reset masks ready so no handshake completes while it is held.
    assign accept       = (state_q == ST_IDLE) && (req_vld != 2'b00) && !reset;
    assign req0_ready_o = accept && gnt[0];
    assign req1_ready_o = accept && gnt[1];

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .reset  (reset),
        .req    (req_vld),
        .accept (accept),
        .gnt    (gnt)
    );

    // Operand/op mux toward the ALU drive registers, following the grant.
    always_comb begin
        sel_a_d  = gnt[1] ? req1_a_i  : req0_a_i;
        sel_b_d  = gnt[1] ? req1_b_i  : req0_b_i;
        sel_op_d = gnt[1] ? req1_op_i : req0_op_i;
    end

`ifdef ALU_ARB_OPCHECK_EN
    logic op_err_q;
    logic op_err_d;

    // Illegal op codes are replaced by ADD so the ALU never sees them.
    always_comb begin
        op_err_d = (sel_op_d > ALU_OP_MAX);
        alu_op_d = op_err_d ? ALU_ADD : sel_op_d;
    end

    assign resp_err_o = (state_q == ST_RESP) && op_err_q;

    // Error flag travels with the transaction from accept to RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_err_q <= 1'b0;
        end else if (accept) begin
            op_err_q <= op_err_d;
        end
    end
`else
    // Op codes pass through unchanged.
    always_comb begin
        alu_op_d = sel_op_d;
    end
`endif

    assign resp_take = gnt_idx_q ? resp1_ready_i : resp0_ready_i;

    // Arbiter FSM with registered ALU drive and result; ALU drive holds outside accepts.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            gnt_idx_q   <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= ALU_ADD;
            resp_data_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        gnt_idx_q <= gnt[1];
                        alu_a_q   <= sel_a_d;
                        alu_b_q   <= sel_b_d;
                        alu_op_q  <= alu_op_d;
                        state_q   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
`ifdef ALU_ARB_OPCHECK_EN
                    resp_data_q <= op_err_q ? '0 : alu_result_i;
`else
                    resp_data_q <= alu_result_i;
`endif
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_take) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign resp0_valid_o = (state_q == ST_RESP) && !gnt_idx_q;
    assign resp1_valid_o = (state_q == ST_RESP) &&  gnt_idx_q;
    assign resp_data_o   = resp_data_q;
    assign alu_a_o       = alu_a_q;
    assign alu_b_o       = alu_b_q;
    assign alu_op_o      = alu_op_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed testbench for alu_share_arbiter with a behavioural ALU attached.
// Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid_i = 1'b0, req1_valid_i = 1'b0;
    logic        req0_ready_o, req1_ready_o;
    logic [31:0] req0_a_i = '0, req1_a_i = '0, req0_b_i = '0, req1_b_i = '0;
    logic [3:0]  req0_op_i = '0, req1_op_i = '0;
    logic        resp0_valid_o, resp1_valid_o;
    logic        resp0_ready_i = 1'b1, resp1_ready_i = 1'b1;
    logic [31:0] resp_data_o, alu_a_o, alu_b_o;
    logic [3:0]  alu_op_o;
    logic [31:0] alu_result_i;
`ifdef ALU_ARB_OPCHECK_EN
    logic        resp_err_o;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req0_valid_i(req0_valid_i), .req1_valid_i(req1_valid_i),
        .req0_ready_o(req0_ready_o), .req1_ready_o(req1_ready_o),
        .req0_a_i(req0_a_i), .req1_a_i(req1_a_i),
        .req0_b_i(req0_b_i), .req1_b_i(req1_b_i),
        .req0_op_i(req0_op_i), .req1_op_i(req1_op_i),
        .resp0_valid_o(resp0_valid_o), .resp1_valid_o(resp1_valid_o),
        .resp0_ready_i(resp0_ready_i), .resp1_ready_i(resp1_ready_i),
        .resp_data_o(resp_data_o),
        .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
`ifdef ALU_ARB_OPCHECK_EN
        .resp_err_o(resp_err_o),
`endif
        .alu_result_i(alu_result_i)
    );

    // Behavioural ALU; unknown op codes yield a recognisable marker.
    always_comb begin
        case (alu_op_o)
            4'b0000: alu_result_i = alu_a_o + alu_b_o;
            4'b0001: alu_result_i = alu_a_o | alu_b_o;
            4'b0010: alu_result_i = alu_a_o << alu_b_o[4:0];
            4'b0011: alu_result_i = alu_a_o >> alu_b_o[4:0];
            default: alu_result_i = 32'hDEAD_BEEF;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " req0_ready"}, 32'(req0_ready_o), 32'd0);
        chk({tag, " req1_ready"}, 32'(req1_ready_o), 32'd0);
        chk({tag, " resp0_valid"}, 32'(resp0_valid_o), 32'd0);
        chk({tag, " resp1_valid"}, 32'(resp1_valid_o), 32'd0);
        chk({tag, " resp_data"}, resp_data_o, 32'd0);
        chk({tag, " alu_a"}, alu_a_o, 32'd0);
        chk({tag, " alu_b"}, alu_b_o, 32'd0);
        chk({tag, " alu_op"}, 32'(alu_op_o), 32'd0);
`ifdef ALU_ARB_OPCHECK_EN
        chk({tag, " resp_err"}, 32'(resp_err_o), 32'd0);
`endif
    endtask

    initial begin
        // ---------------- reset ----------------
        tick(); tick();
        chk_reset_vals("rst");
        reset = 1'b0;

        // ---------------- req0 ADD 5+7 ----------------
        req0_valid_i = 1'b1; req0_a_i = 32'd5; req0_b_i = 32'd7; req0_op_i = 4'b0000;
        settle();
        chk("add ready0 same cycle", 32'(req0_ready_o), 32'd1);
        chk("add ready1 idle", 32'(req1_ready_o), 32'd0);
        tick();
        req0_valid_i = 1'b0;
        settle();
        chk("add alu_a", alu_a_o, 32'd5);
        chk("add alu_b", alu_b_o, 32'd7);
        chk("add alu_op", 32'(alu_op_o), 32'd0);
        chk("add exec no resp", 32'(resp0_valid_o), 32'd0);
        tick();
        chk("add resp0_valid", 32'(resp0_valid_o), 32'd1);
        chk("add resp1_valid", 32'(resp1_valid_o), 32'd0);
        chk("add data", resp_data_o, 32'd12);
        tick();
        chk("add back idle", 32'(resp0_valid_o), 32'd0);

        // ---------------- both valid from reset ----------------
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0_valid_i = 1'b1; req0_a_i = 32'd3; req0_b_i = 32'd4; req0_op_i = 4'b0000;
        req1_valid_i = 1'b1; req1_a_i = 32'h0F; req1_b_i = 32'hF0; req1_op_i = 4'b0001;
        settle();
        chk("both ready0", 32'(req0_ready_o), 32'd1);
        chk("both ready1", 32'(req1_ready_o), 32'd0);
        tick();
        req0_valid_i = 1'b0;
        settle();
        chk("both exec ready1", 32'(req1_ready_o), 32'd0);
        tick();
        chk("both resp0", 32'(resp0_valid_o), 32'd1);
        chk("both data0", resp_data_o, 32'd7);
        chk("both resp ready1", 32'(req1_ready_o), 32'd0);
        tick();
        chk("both ready1 idle", 32'(req1_ready_o), 32'd1);
        tick();
        req1_valid_i = 1'b0;
        tick();
        chk("both resp1", 32'(resp1_valid_o), 32'd1);
        chk("both resp0 quiet", 32'(resp0_valid_o), 32'd0);
        chk("both data1 OR", resp_data_o, 32'hFF);
        tick();

        // ---------------- 4 back-to-back pairs, pointer alternation ----------------
        req0_valid_i = 1'b1;
        req1_valid_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            settle();
            chk($sformatf("rr%0d ready0", k), 32'(req0_ready_o), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr%0d ready1", k), 32'(req1_ready_o), (k % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            tick();
            chk($sformatf("rr%0d resp0", k), 32'(resp0_valid_o), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr%0d resp1", k), 32'(resp1_valid_o), (k % 2 == 1) ? 32'd1 : 32'd0);
            chk($sformatf("rr%0d data", k), resp_data_o, (k % 2 == 0) ? 32'd7 : 32'hFF);
            if (k == 7) begin
                req0_valid_i = 1'b0;
                req1_valid_i = 1'b0;
            end
            tick();
        end

        // ---------------- response backpressure ----------------
        resp0_ready_i = 1'b0;
        req0_valid_i = 1'b1; req0_a_i = 32'd10; req0_b_i = 32'd20; req0_op_i = 4'b0000;
        req1_valid_i = 1'b1; req1_a_i = 32'd1;  req1_b_i = 32'd31; req1_op_i = 4'b0010;
        settle();
        chk("bp ready0", 32'(req0_ready_o), 32'd1);
        tick();
        req0_valid_i = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d resp0", c), 32'(resp0_valid_o), 32'd1);
            chk($sformatf("bp%0d data", c), resp_data_o, 32'd30);
            chk($sformatf("bp%0d ready1", c), 32'(req1_ready_o), 32'd0);
            tick();
        end
        resp0_ready_i = 1'b1;
        settle();
        chk("bp handshake ready1", 32'(req1_ready_o), 32'd0);
        tick();
        chk("bp req1 granted", 32'(req1_ready_o), 32'd1);
        chk("bp resp0 done", 32'(resp0_valid_o), 32'd0);
        tick();
        req1_valid_i = 1'b0;
        settle();
        chk("sll alu_op", 32'(alu_op_o), 32'd2);
        tick();
        chk("sll resp1", 32'(resp1_valid_o), 32'd1);
        chk("sll data", resp_data_o, 32'h8000_0000);
        tick();

        // ---------------- SRL ----------------
        req0_valid_i = 1'b1; req0_a_i = 32'h8000_0000; req0_b_i = 32'd31; req0_op_i = 4'b0011;
        settle();
        chk("srl ready0", 32'(req0_ready_o), 32'd1);
        tick();
        req0_valid_i = 1'b0;
        tick();
        chk("srl resp0", 32'(resp0_valid_o), 32'd1);
        chk("srl data", resp_data_o, 32'd1);
        tick();

        // ---------------- reset during EXEC ----------------
        req1_valid_i = 1'b1; req1_a_i = 32'd2; req1_b_i = 32'd3; req1_op_i = 4'b0000;
        settle();
        chk("rx ready1", 32'(req1_ready_o), 32'd1);
        tick();
        chk("rx exec alu_a", alu_a_o, 32'd2);
        reset = 1'b1;
        tick();
        chk_reset_vals("rx");
        reset = 1'b0;
        settle();
        chk("rx regrant ready1", 32'(req1_ready_o), 32'd1);
        chk("rx no resp1", 32'(resp1_valid_o), 32'd0);
        tick();
        req1_valid_i = 1'b0;
        tick();
        chk("rx resp1", 32'(resp1_valid_o), 32'd1);
        chk("rx data", resp_data_o, 32'd5);
        tick();

        // ---------------- out-of-range op code ----------------
        req0_valid_i = 1'b1; req0_a_i = 32'd9; req0_b_i = 32'd9; req0_op_i = 4'b1010;
        settle();
        chk("bad ready0", 32'(req0_ready_o), 32'd1);
        tick();
        req0_valid_i = 1'b0;
        settle();
`ifdef ALU_ARB_OPCHECK_EN
        chk("bad alu_op forced", 32'(alu_op_o), 32'd0);
        tick();
        chk("bad resp0", 32'(resp0_valid_o), 32'd1);
        chk("bad err", 32'(resp_err_o), 32'd1);
        chk("bad data zero", resp_data_o, 32'd0);
        tick();
        req0_valid_i = 1'b1; req0_a_i = 32'd1; req0_b_i = 32'd1; req0_op_i = 4'b0000;
        tick();
        req0_valid_i = 1'b0;
        tick();
        chk("good err", 32'(resp_err_o), 32'd0);
        chk("good data", resp_data_o, 32'd2);
        tick();
`else
        chk("op passthrough", 32'(alu_op_o), 32'hA);
        tick();
        chk("op passthrough resp0", 32'(resp0_valid_o), 32'd1);
        chk("op passthrough data", resp_data_o, 32'hDEAD_BEEF);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequential front-end that shares the single combinational ALU (4-bit operation code: ADD, OR, SLL, SRL) between two requesters, e.g. the core datapath and an address-generation or debug unit. It arbitrates round-robin and registers the chosen operands and operation into the ALU's input ports. It then captures the ALU result and returns it to the granted requester over a valid/ready response channel.

## Interface
- DATA_WIDTH, 32, operand/result width
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid_i / req1_valid_i  in  1  requester n has an operation pending
- req0_ready_o / req1_ready_o  out  1  request n accepted this cycle
- req0_a_i / req1_a_i  in  DATA_WIDTH  operand A
- req0_b_i / req1_b_i  in  DATA_WIDTH  operand B (or immediate / shift amount)
- req0_op_i / req1_op_i  in  4  ALU operation code
- resp0_valid_o / resp1_valid_o  out  1  result for requester n is available
- resp0_ready_i / resp1_ready_i  in  1  requester n consumes the result
- resp_data_o  out  DATA_WIDTH  result, shared by both response channels
- alu_a_o, alu_b_o  out  DATA_WIDTH  ALU operands
- alu_op_o  out  4  drives the ALU's ALU_Operation input
- alu_result_i  in  DATA_WIDTH  combinational ALU result

## Operation
- FSM states:
  - IDLE: request acceptance.
  - EXEC: ALU evaluation.
  - RESP: result held for the granted requester.
- IDLE:
  - If either req valid, grant one requester, assert its req_ready_o combinationally, latch a/b/op into the ALU drive registers and the grant index, then go to EXEC.
  - Otherwise stay in IDLE.
- Grant rule:
  - Both valid: grant the requester named by the priority pointer.
  - One valid: grant it regardless of the pointer.
  - On every accept, the pointer is set to the non-granted index.
- EXEC: alu_a_o/alu_b_o/alu_op_o are stable from registers; alu_result_i is captured into resp_data_o at the end of the cycle; next state is RESP.
- RESP: resp{g}_valid_o=1 and resp_data_o is held until resp{g}_ready_i=1; then go to IDLE. The other channel's valid stays 0.
- ALU drive registers keep their last values outside EXEC, so the ALU sees no spurious toggling.
- Requester protocol: valid, a, b and op must be held stable until ready. A requester whose request was not granted keeps valid high and is served after the current transaction.
- Width: operands and result are passed through unmodified; no extension or truncation.
- Reset mid-transaction: the transaction is dropped and no response is issued. The requester must re-issue.

## Timing
- Reset values:
  - state=IDLE, pointer=0 (req0 priority).
  - All req_ready_o=0 and resp_valid_o=0.
  - resp_data_o=0, alu_a_o=0, alu_b_o=0, alu_op_o=4'b0000.
- Latency: request accepted in cycle N, ALU driven in cycle N+1, resp_valid_o=1 in cycle N+2.
- Throughput: one operation per 3 cycles when responses are consumed immediately. Response backpressure extends RESP indefinitely.
- req_ready_o is high only in IDLE, for at most one requester per cycle.
- Request acceptance does not overlap RESP. A valid request arriving during EXEC/RESP waits.

## Configuration
- ALU_ARB_OPCHECK_EN defined: adds output resp_err_o (1 bit, reset 0).
  - Op codes outside 4'b0000–4'b0011 are still accepted, but alu_op_o is forced to 4'b0000.
  - resp_data_o=0 and resp_err_o=1 during RESP.
  - Legal op codes give resp_err_o=0.
- Not defined: every op code is forwarded unchanged to alu_op_o and no resp_err_o port exists.

## Structure
- Shared package alu_pkg holds:
  - ALU op constants ALU_ADD=4'b0000, ALU_OR=4'b0001, ALU_SLL=4'b0010, ALU_SRL=4'b0011, ALU_OP_MAX=4'b0011.
  - The arbiter state encoding (IDLE/EXEC/RESP).
- The ALU control decoder can use the same op constants.
- Sub-module rr_arb2: combinational two-way round-robin grant plus the registered priority pointer, with inputs req[1:0] and accept, and outputs gnt[1:0].

## Test plan
- Reset, then req0 only with a=5, b=7, op=ADD:
  - req0_ready_o=1 in the same cycle, alu_op_o=0000 one cycle later.
  - resp0_valid_o=1 with resp_data_o=12 two cycles after accept.
- Both valid from reset, req1 with a=0x0F, b=0xF0, op=OR:
  - req0 served first, then req1 with resp_data_o=0xFF.
  - Pointer alternation is visible over 4 back-to-back pairs.
- resp0_ready_i held low 5 cycles while req1 is valid:
  - resp0_valid_o and resp_data_o stay stable.
  - req1_ready_o stays 0 until the response handshake, then req1 is granted next cycle.
- SLL with a=1, b=31 gives resp_data_o=0x80000000. SRL with a=0x80000000, b=31 gives 1.
- Reset asserted during EXEC: next cycle all outputs are at reset values, no resp_valid_o appears, and the pending request is re-granted after reset.
- With ALU_ARB_OPCHECK_EN, op=4'b1010:
  - alu_op_o=0000, resp_err_o=1, resp_data_o=0.
  - A following legal ADD gives resp_err_o=0.
